pipeline_step_ctrl: RTL
=======================

# pipeline_step_ctrl

Run/step sequencer for the five-stage pipeline. Drives the shared enable for the PC and every inter-stage latch (IF/ID through MEM/WB), and a separate fetch enable. Supports continuous run, single-cycle step and abort. When a halt instruction is fetched, it drains the in-flight instructions through write-back and then freezes the pipeline with a done flag. The block sits between the debug/host command interface and the datapath enables.

## Interface

- DRAIN_CYCLES, 4, number of enabled cycles after halt fetch needed for the halt to retire from MEM/WB (≥1)
- CNT_W, 32, width of the executed-cycle counter
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_run  in  1  start continuous execution (level sampled each edge)
- i_step  in  1  advance pipeline exactly one cycle (level sampled each edge)
- i_abort  in  1  force immediate stop to DONE
- i_halt_fetched  in  1  halt opcode present at IF this cycle
- o_pipe_en  out  1  enable for PC and all pipeline latches
- o_fetch_en  out  1  PC update / new-instruction fetch permission
- o_busy  out  1  high in RUN, STEP, DRAIN
- o_done  out  1  high in DONE
- o_cycle_cnt  out  CNT_W  count of cycles with o_pipe_en=1

## Operation

- States: IDLE, RUN, STEP, DRAIN, DONE. All outputs are Moore, decoded from registered state, pending flag and counters.
- Internal state: halt_pend (1 bit) and drain_cnt (clog2(DRAIN_CYCLES+1) bits).
- IDLE: pipe_en=0, fetch_en=0. i_run → RUN. If halt_pend is set, i_run → DRAIN instead. i_step → STEP. If i_run and i_step are both high, i_run wins.
- RUN: pipe_en=1, fetch_en=1. i_halt_fetched → DRAIN, with drain_cnt←DRAIN_CYCLES and halt_pend←1. i_run and i_step are ignored.
- DRAIN: pipe_en=1, fetch_en=0. drain_cnt decrements each edge. At the edge where drain_cnt==1 → DONE with drain_cnt=0. i_halt_fetched, i_run and i_step are ignored.
- STEP: pipe_en=1, fetch_en=~halt_pend. Next edge always leaves STEP:
  - If halt_pend=0 and i_halt_fetched: set halt_pend, load drain_cnt←DRAIN_CYCLES → IDLE.
  - If halt_pend=1: decrement drain_cnt. → DONE if drain_cnt==1, else → IDLE.
  - Otherwise → IDLE.
- DONE: pipe_en=0, fetch_en=0, done=1. Terminal; only rst leaves it.
- i_abort has the highest priority in every state except DONE. It causes → DONE at the next edge. The cycle counter still counts that final enabled cycle if pipe_en was 1.
- o_cycle_cnt increments on each edge where o_pipe_en=1. It saturates at 2^CNT_W−1 and does not wrap.

## Timing

- Reset (async, immediate): state=IDLE, halt_pend=0, drain_cnt=0, o_pipe_en=0, o_fetch_en=0, o_busy=0, o_done=0, o_cycle_cnt=0.
- Command latency: i_run or i_step sampled high at edge N → o_pipe_en high in the cycle after edge N.
- STEP yields exactly one cycle of o_pipe_en=1, even if i_step is held high. A held i_step re-enters STEP after the one-cycle IDLE gap, giving every-other-cycle stepping.
- Halt in RUN: i_halt_fetched high at edge N, where the halt is latched into IF/ID. o_fetch_en=0 from edge N. o_pipe_en stays 1 for exactly DRAIN_CYCLES more cycles. o_done=1 after edge N+DRAIN_CYCLES.
- Halt found while stepping: the next DRAIN_CYCLES steps have fetch_en=0. After the last one, the next state is DONE. Switching to run mid-drain continues in DRAIN with the remaining count. Total enabled cycles after the halt is always DRAIN_CYCLES.
- Reset asserted mid-RUN or mid-DRAIN: all outputs drop in the same cycle, without waiting for a clock edge. The pending drain is discarded.

## Test plan

- Reset then run: pulse rst, i_run at edge 2, i_halt_fetched at edge 10, DRAIN_CYCLES=4 → o_pipe_en high cycles 3–14, o_fetch_en falls after edge 10, o_done=1 after edge 14, o_cycle_cnt=12.
- Single step: i_step held 1 for 6 edges from IDLE → pipe_en pulses 3 times (1 high, 1 low), o_cycle_cnt=3, o_done=0.
- Stepped drain: halt fetched during a step, then 4 further i_step pulses → fetch_en=0 on each, o_done=1 after the 4th, a 5th i_step has no effect.
- Step-to-run drain handover: halt on a step, 1 more step, then i_run → exactly 3 DRAIN cycles, then DONE. Total enabled cycles after the halt = 4.
- Abort and priority: i_run and i_step together → RUN. i_abort 5 cycles later → DONE next edge. i_run afterwards is ignored. Async rst mid-DRAIN clears all outputs before the next clk edge.
- Counter saturation: CNT_W=4, run 20 cycles without halt → o_cycle_cnt holds 15.

Source files
------------

// File: rtl/pipeline_step_ctrl.sv
// Run/step/abort sequencer driving the pipeline latch enable and the fetch enable.
// Halts drain DRAIN_CYCLES enabled cycles before DONE; all outputs are Moore.
module pipeline_step_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_abort,
  input  logic             i_halt_fetched,
  output logic             o_pipe_en,
  output logic             o_fetch_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              halt_pend, halt_pend_nxt;
  logic [DW-1:0]     drain_cnt, drain_cnt_nxt;
  logic [CNT_W-1:0]  cycle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      halt_pend <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      halt_pend <= halt_pend_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    halt_pend_nxt = halt_pend;
    drain_cnt_nxt = drain_cnt;
    if (i_abort && (state != S_DONE)) begin
      state_nxt = S_DONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_run) begin
            state_nxt = halt_pend ? S_DRAIN : S_RUN;
          end else if (i_step) begin
            state_nxt = S_STEP;
          end
        end
        S_RUN: begin
          if (i_halt_fetched) begin
            state_nxt     = S_DRAIN;
            halt_pend_nxt = 1'b1;
            drain_cnt_nxt = DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          // <= rather than == so a stray zero count can never stall the drain
          if (drain_cnt <= DRAIN_ONE) begin
            state_nxt     = S_DONE;
            drain_cnt_nxt = '0;
          end else begin
            drain_cnt_nxt = drain_cnt - DRAIN_ONE;
          end
        end
        S_STEP: begin
          state_nxt = S_IDLE;
          if (!halt_pend && i_halt_fetched) begin
            halt_pend_nxt = 1'b1;
            drain_cnt_nxt = DRAIN_LOAD;
          end else if (halt_pend) begin
            if (drain_cnt <= DRAIN_ONE) begin
              state_nxt     = S_DONE;
              drain_cnt_nxt = '0;
            end else begin
              drain_cnt_nxt = drain_cnt - DRAIN_ONE;
            end
          end
        end
        S_DONE: state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Saturating count of enabled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (o_pipe_en && (cycle_cnt != {CNT_W{1'b1}})) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  assign o_pipe_en   = (state == S_RUN) || (state == S_STEP) || (state == S_DRAIN);
  assign o_fetch_en  = (state == S_RUN) || ((state == S_STEP) && !halt_pend);
  assign o_busy      = o_pipe_en;
  assign o_done      = (state == S_DONE);
  assign o_cycle_cnt = cycle_cnt;

endmodule
